// File: rtl/mem_stage_lsm_pkg.sv
// Shared opcode values, FSM state encoding and opcode-class helpers for the
// memory-access stage.
package mem_stage_lsm_pkg;

    localparam logic [3:0] OP_LW = 4'b0100;
    localparam logic [3:0] OP_SW = 4'b0101;
    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MULTI  = 2'd2
    } state_e;

    function automatic logic is_single(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_multi(input logic [3:0] op);
        return (op == OP_LM) || (op == OP_SM);
    endfunction

endpackage

// File: rtl/mem_stage_lsm_lsb_pick.sv
// Lowest-set-bit priority encoder: index of the lowest 1 in the mask, plus an
// any-bit-set flag.
module lsb_pick #(
    parameter  int NREG  = 8,
    localparam int REG_W = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic [NREG-1:0]  i_mask,
    output logic [REG_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        o_idx = '0;
        o_any = |i_mask;
        // Scan downwards so the lowest set bit is the last (winning) write.
        for (int i = NREG - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = REG_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_stage_lsm.sv
// Memory-access pipeline stage: LW/SW, multi-cycle LM/SM over a register mask,
// req/ack data-memory handshake, store-data forwarding from write-back.
module mem_stage_lsm
    import mem_stage_lsm_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int ADDR_W = 16,
    parameter  int NREG   = 8,
    localparam int REG_W  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [REG_W-1:0]  in_rega,
    input  logic [NREG-1:0]   in_mask,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_sdata,
    input  logic [DATA_W-1:0] in_wbdata,
    input  logic [REG_W-1:0]  in_wbreg,
    input  logic              in_wben,
    input  logic              fwd_valid,
    input  logic [REG_W-1:0]  fwd_reg,
    input  logic [DATA_W-1:0] fwd_data,
    output logic [REG_W-1:0]  rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic              out_we,
    output logic [REG_W-1:0]  out_reg,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    state_e            r_state;
    state_e            w_state_nxt;

    logic              r_is_load;
    logic [REG_W-1:0]  r_rega;
    logic [NREG-1:0]   r_mask;
    logic [REG_W-1:0]  r_cur;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_out_valid;
    logic              r_out_we;
    logic [REG_W-1:0]  r_out_reg;
    logic [DATA_W-1:0] r_out_data;

    logic              w_is_load;
    logic [REG_W-1:0]  w_rega;
    logic [NREG-1:0]   w_mask;
    logic [REG_W-1:0]  w_cur;
    logic              w_mem_req;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_out_valid;
    logic              w_out_we;
    logic [REG_W-1:0]  w_out_reg;
    logic [DATA_W-1:0] w_out_data;

    logic [NREG-1:0]   w_pick_mask;
    logic [REG_W-1:0]  w_pick_idx;
    logic              w_pick_any;
    logic [NREG-1:0]   w_rem;
    logic              w_ack;
    logic              w_fwd_hit;

    // The lowest set bit of r_mask is always the register being transferred,
    // so clearing it is just "drop the lowest 1".
    assign w_rem     = r_mask & (r_mask - {{(NREG-1){1'b0}}, 1'b1});
    assign w_ack     = mem_ack && r_mem_req;
    assign w_fwd_hit = fwd_valid && (fwd_reg == in_rega);

    lsb_pick #(
        .NREG(NREG)
    ) u_lsb_pick (
        .i_mask(w_pick_mask),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // The picker looks at the register the *next* issued transfer will use,
    // so SM store data can be read combinationally and registered with it.
    assign rf_raddr = w_pick_idx;

    always_comb begin
        w_state_nxt = r_state;
        w_is_load   = r_is_load;
        w_rega      = r_rega;
        w_mask      = r_mask;
        w_cur       = r_cur;
        w_mem_req   = r_mem_req;
        w_mem_we    = r_mem_we;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_out_valid = 1'b0;
        w_out_we    = 1'b0;
        w_out_reg   = r_out_reg;
        w_out_data  = r_out_data;
        w_pick_mask = '0;

        unique case (r_state)
            ST_IDLE: begin
                w_pick_mask = in_valid ? in_mask : '0;
                if (in_valid) begin
                    if (is_single(in_op)) begin
                        w_state_nxt = ST_ACCESS;
                        w_is_load   = (in_op == OP_LW);
                        w_rega      = in_rega;
                        w_mem_req   = 1'b1;
                        w_mem_we    = (in_op == OP_SW);
                        w_mem_addr  = in_addr;
                        w_mem_wdata = w_fwd_hit ? fwd_data : in_sdata;
                    end else if (is_multi(in_op)) begin
                        if (w_pick_any) begin
                            w_state_nxt = ST_MULTI;
                            w_is_load   = (in_op == OP_LM);
                            w_mask      = in_mask;
                            w_cur       = w_pick_idx;
                            w_mem_req   = 1'b1;
                            w_mem_we    = (in_op == OP_SM);
                            w_mem_addr  = in_addr;
                            w_mem_wdata = rf_rdata;
                        end else begin
                            w_out_valid = 1'b1;
                        end
                    end else begin
                        w_out_valid = 1'b1;
                        w_out_we    = in_wben;
                        w_out_reg   = in_wbreg;
                        w_out_data  = in_wbdata;
                    end
                end
            end

            ST_ACCESS: begin
                if (w_ack) begin
                    w_state_nxt = ST_IDLE;
                    w_mem_req   = 1'b0;
                    w_mem_we    = 1'b0;
                    w_out_valid = 1'b1;
                    w_out_we    = r_is_load;
                    if (r_is_load) begin
                        w_out_reg  = r_rega;
                        w_out_data = mem_rdata;
                    end
                end
            end

            ST_MULTI: begin
                w_pick_mask = w_ack ? w_rem : r_mask;
                if (w_ack) begin
                    w_mask = w_rem;
                    if (r_is_load) begin
                        w_out_valid = 1'b1;
                        w_out_we    = 1'b1;
                        w_out_reg   = r_cur;
                        w_out_data  = mem_rdata;
                    end
                    if (!w_pick_any) begin
                        w_state_nxt = ST_IDLE;
                        w_mem_req   = 1'b0;
                        w_mem_we    = 1'b0;
                        if (!r_is_load) begin
                            w_out_valid = 1'b1;
                        end
                    end else begin
                        w_cur      = w_pick_idx;
                        w_mem_addr = r_mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        if (!r_is_load) begin
                            w_mem_wdata = rf_rdata;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_mem_req   = 1'b0;
                w_mem_we    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_is_load   <= 1'b0;
            r_rega      <= '0;
            r_mask      <= '0;
            r_cur       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_out_valid <= 1'b0;
            r_out_we    <= 1'b0;
            r_out_reg   <= '0;
            r_out_data  <= '0;
        end else begin
            r_is_load   <= w_is_load;
            r_rega      <= w_rega;
            r_mask      <= w_mask;
            r_cur       <= w_cur;
            r_mem_req   <= w_mem_req;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_out_valid <= w_out_valid;
            r_out_we    <= w_out_we;
            r_out_reg   <= w_out_reg;
            r_out_data  <= w_out_data;
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign out_valid = r_out_valid;
    assign out_we    = r_out_we;
    assign out_reg   = r_out_reg;
    assign out_data  = r_out_data;

endmodule
